// File: rtl/pt_fetcher_pack.sv
// rtl/pt_fetcher_pack.sv - read-modify-write pixel packer between transform stage and pixel memory
//
// Accepts transformed points into a small FIFO, reads the packed memory word
// holding each point, inserts the pixel into its lane and writes the word back.
// Consecutive points landing in the same word share one read/write pair.
//
// Ports:
//   clock, reset                  rising-edge clock, asynchronous active-low reset
//   pt_flag/done_pt               point valid / ready (accept when both high)
//   pt_x, pt_y, pt_pixel          point coordinates and truncated pixel
//   transparent                   1 = zero pixels leave the memory lane untouched
//   ptf_flag/done_ptf             memory request valid / acknowledge
//   ptf_wr                        0 = read, 1 = write
//   ptf_x, ptf_y                  word-aligned memory address
//   ptf_pixel_write               write data
//   ptf_pixel_read                read data, sampled on the read acknowledge
module pt_fetcher_pack #(
    parameter int PIX_W     = 12,
    parameter int LOG_PPW   = 2,
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int LOG_DEPTH = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          pt_flag,
    input  logic [X_W-1:0]                pt_x,
    input  logic [Y_W-1:0]                pt_y,
    input  logic [PIX_W-1:0]              pt_pixel,
    output logic                          done_pt,
    input  logic                          transparent,
    output logic                          ptf_flag,
    output logic                          ptf_wr,
    output logic [X_W-1:0]                ptf_x,
    output logic [Y_W-1:0]                ptf_y,
    output logic [(PIX_W<<LOG_PPW)-1:0]   ptf_pixel_write,
    input  logic                          done_ptf,
    input  logic [(PIX_W<<LOG_PPW)-1:0]   ptf_pixel_read
);

    localparam int PPW   = 1 << LOG_PPW;
    localparam int MEM_W = PIX_W * PPW;
    localparam int DEPTH = 1 << LOG_DEPTH;

    typedef enum logic [1:0] {IDLE, READ, MERGE, WRITE} state_t;

    state_t state, state_n;

    logic [X_W-1:0]   fifo_x   [DEPTH];
    logic [Y_W-1:0]   fifo_y   [DEPTH];
    logic [PIX_W-1:0] fifo_pix [DEPTH];
    logic [LOG_DEPTH:0] wr_ptr, rd_ptr;
    logic empty, full, push, pop;

    // Holds done_pt low for the first cycle after reset is released.
    logic running;

    logic [X_W-1:0]   cur_x, head_x;
    logic [Y_W-1:0]   cur_y, head_y;
    logic [PIX_W-1:0] cur_pix, head_pix;
    logic [MEM_W-1:0] wbuf, wbuf_n;
    logic flag_q, flag_n, wr_q, wr_n;
    logic same_word;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[LOG_DEPTH] != rd_ptr[LOG_DEPTH]) &&
                   (wr_ptr[LOG_DEPTH-1:0] == rd_ptr[LOG_DEPTH-1:0]);
    assign done_pt = running & ~full;
    assign push    = pt_flag & done_pt;

    assign head_x   = fifo_x[rd_ptr[LOG_DEPTH-1:0]];
    assign head_y   = fifo_y[rd_ptr[LOG_DEPTH-1:0]];
    assign head_pix = fifo_pix[rd_ptr[LOG_DEPTH-1:0]];

    assign same_word = (head_y == cur_y) &&
                       (head_x[X_W-1:LOG_PPW] == cur_x[X_W-1:LOG_PPW]);

    // The address comes straight from cur; cur only changes in IDLE or in
    // MERGE (same word), so it is stable for the whole request.
    assign ptf_flag        = flag_q;
    assign ptf_wr          = wr_q;
    assign ptf_x           = {cur_x[X_W-1:LOG_PPW], {LOG_PPW{1'b0}}};
    assign ptf_y           = cur_y;
    assign ptf_pixel_write = wbuf;

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_x[wr_ptr[LOG_DEPTH-1:0]]   <= pt_x;
            fifo_y[wr_ptr[LOG_DEPTH-1:0]]   <= pt_y;
            fifo_pix[wr_ptr[LOG_DEPTH-1:0]] <= pt_pixel;
        end
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        flag_n  = flag_q;
        wr_n    = wr_q;
        wbuf_n  = wbuf;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = READ;
                end
            end
            READ: begin
                // First cycle in READ raises the request; ack counts only once it is up.
                if (!flag_q) begin
                    flag_n = 1'b1;
                    wr_n   = 1'b0;
                end else if (done_ptf) begin
                    flag_n  = 1'b0;
                    wbuf_n  = ptf_pixel_read;
                    state_n = MERGE;
                end
            end
            MERGE: begin
                if (!(transparent && (cur_pix == '0))) begin
                    for (int k = 0; k < PPW; k++) begin
                        if (cur_x[LOG_PPW-1:0] == LOG_PPW'(k)) begin
                            wbuf_n[k*PIX_W +: PIX_W] = cur_pix;
                        end
                    end
                end
                if (!empty && same_word) begin
                    pop = 1'b1;
                end else begin
                    state_n = WRITE;
                end
            end
            WRITE: begin
                if (!flag_q) begin
                    flag_n = 1'b1;
                    wr_n   = 1'b1;
                end else if (done_ptf) begin
                    flag_n  = 1'b0;
                    wr_n    = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            running <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cur_x   <= '0;
            cur_y   <= '0;
            cur_pix <= '0;
            wbuf    <= '0;
            flag_q  <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state   <= state_n;
            running <= 1'b1;
            flag_q  <= flag_n;
            wr_q    <= wr_n;
            wbuf    <= wbuf_n;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                cur_x   <= head_x;
                cur_y   <= head_y;
                cur_pix <= head_pix;
            end
        end
    end

endmodule

// File: tb/tb_pt_fetcher_pack.sv
// tb/tb_pt_fetcher_pack.sv - scoreboard testbench for pt_fetcher_pack
module tb_pt_fetcher_pack;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pt_flag = 1'b0;
    logic [9:0]  pt_x = '0;
    logic [9:0]  pt_y = '0;
    logic [11:0] pt_pixel = '0;
    logic        transparent = 1'b0;
    logic        done_ptf = 1'b0;
    logic [47:0] ptf_pixel_read = '0;
    logic        done_pt, ptf_flag, ptf_wr;
    logic [9:0]  ptf_x, ptf_y;
    logic [47:0] ptf_pixel_write;

    pt_fetcher_pack dut (
        .clock(clock), .reset(reset),
        .pt_flag(pt_flag), .pt_x(pt_x), .pt_y(pt_y), .pt_pixel(pt_pixel),
        .done_pt(done_pt), .transparent(transparent),
        .ptf_flag(ptf_flag), .ptf_wr(ptf_wr), .ptf_x(ptf_x), .ptf_y(ptf_y),
        .ptf_pixel_write(ptf_pixel_write), .done_ptf(done_ptf),
        .ptf_pixel_read(ptf_pixel_read)
    );

    always #5 clock = ~clock;

    typedef struct {logic [9:0] x; logic [9:0] y; logic [11:0] pix;} pt_t;
    typedef struct {logic wr; logic [9:0] x; logic [9:0] y; logic [47:0] d;} txn_t;

    pt_t         exp_q[$];
    txn_t        log_q[$];
    logic [47:0] rd_force_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          hold_ack = 1'b0;
    bit          busy = 1'b0;
    int          wait_cnt = 0;
    txn_t        cur_t;
    logic [47:0] last_r = '0;
    logic [17:0] last_key = '0;

    task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, got, exp);
        end
    endtask

    function automatic logic [17:0] key_of(input logic [9:0] x, input logic [9:0] y);
        return {y, x[9:2]};
    endfunction

    // Word after the first n queued points are dropped into their lanes, last one winning.
    function automatic logic [47:0] apply_pts(input logic [47:0] base, input int n);
        logic [47:0] w = base;
        for (int i = 0; i < n; i++) begin
            if (!(transparent && exp_q[i].pix == 12'h0))
                w[int'(exp_q[i].x % 4) * 12 +: 12] = exp_q[i].pix;
        end
        return w;
    endfunction

    task automatic complete();
        logic [47:0] r;
        logic [17:0] hk;
        logic [47:0] exp_d;
        int runlen;
        int n_match;
        if (!cur_t.wr) begin
            hk = (exp_q.size() > 0) ? key_of(exp_q[0].x, exp_q[0].y) : 18'h3ffff;
            chk("rd_addr", {exp_q.size() == 0, ptf_x[1:0], key_of(ptf_x, ptf_y)},
                {1'b0, 2'b00, hk});
            if (rd_force_q.size() > 0) begin
                r = rd_force_q.pop_front();
            end else begin
                for (int k = 0; k < 4; k++) r[k*12 +: 12] = {1'b1, 11'($urandom)};
            end
            ptf_pixel_read = r;
            last_r   = r;
            last_key = key_of(ptf_x, ptf_y);
            log_q.push_back('{1'b0, ptf_x, ptf_y, r});
        end else begin
            chk("wr_addr", {ptf_x[1:0], key_of(ptf_x, ptf_y)}, {2'b00, last_key});
            runlen = 0;
            while (runlen < exp_q.size() &&
                   key_of(exp_q[runlen].x, exp_q[runlen].y) == last_key) runlen++;
            n_match = 0;
            for (int n = runlen; n >= 1; n--)
                if (n_match == 0 && apply_pts(last_r, n) == ptf_pixel_write) n_match = n;
            if (runlen == 0) exp_d = last_r;
            else exp_d = apply_pts(last_r, (n_match > 0) ? n_match : runlen);
            chk("wr_data", {runlen == 0, ptf_pixel_write}, {1'b0, exp_d});
            for (int i = 0; i < ((n_match > 0) ? n_match : 1); i++)
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            log_q.push_back('{1'b1, ptf_x, ptf_y, ptf_pixel_write});
        end
    endtask

    // Memory responder and monitor: random ack delay, checks every completed request.
    always @(negedge clock) begin
        if (!reset) begin
            done_ptf = 1'b0;
            busy     = 1'b0;
        end else if (done_ptf) begin
            done_ptf = 1'b0;
            busy     = 1'b0;
            chk("flag_drop", {79'h0, ptf_flag}, 80'h0);
        end else if (ptf_flag) begin
            if (!busy) begin
                busy     = 1'b1;
                wait_cnt = int'($urandom_range(0, 3));
                cur_t    = '{ptf_wr, ptf_x, ptf_y, ptf_pixel_write};
            end else begin
                chk("stable", {ptf_wr, ptf_x, ptf_y, ptf_wr ? ptf_pixel_write : 48'h0},
                    {cur_t.wr, cur_t.x, cur_t.y, cur_t.wr ? cur_t.d : 48'h0});
            end
            if (!hold_ack) begin
                if (wait_cnt == 0) begin
                    done_ptf = 1'b1;
                    complete();
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    task automatic send(input logic [9:0] x, input logic [9:0] y, input logic [11:0] pix);
        int t = 0;
        @(negedge clock);
        pt_x = x; pt_y = y; pt_pixel = pix; pt_flag = 1'b1;
        while (!done_pt && t < 3000) begin
            @(negedge clock);
            t++;
        end
        chk("accept", {79'h0, done_pt}, 80'h1);
        if (done_pt) begin
            exp_q.push_back('{x, y, pix});
            @(posedge clock);
            #1;
        end
        pt_flag = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || ptf_flag || busy) && t < 5000) begin
            @(negedge clock);
            t++;
        end
        repeat (3) @(negedge clock);
        chk("drain", {exp_q.size() == 0, ptf_flag, done_pt}, {1'b1, 1'b0, 1'b1});
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] prev_key;
        logic [9:0]  rx, ry;
        logic [11:0] used[5];
        logic [11:0] p;
        int len;
        int lane;
        int t;
        bit dup;

        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_outputs", {ptf_flag, ptf_wr, ptf_x, ptf_y, ptf_pixel_write, done_pt}, 80'h0);
        reset = 1'b1;
        #1 chk("done_pt_pre_edge", {79'h0, done_pt}, 80'h0);
        @(negedge clock);
        chk("done_pt_release", {79'h0, done_pt}, 80'h1);

        // Single point, with read latency
        log_q.delete();
        rd_force_q.push_back(48'h111222333444);
        send(10'd123, 10'd321, 12'hABC);
        @(negedge clock);
        @(negedge clock);
        chk("lat_edge1", {79'h0, ptf_flag}, 80'h0);
        @(negedge clock);
        chk("lat_edge2", {79'h0, ptf_flag}, 80'h1);
        drain();
        chk("t2_len", 80'(log_q.size()), 80'd2);
        chk("t2_rd", {log_q[0].wr, log_q[0].x, log_q[0].y}, {1'b0, 10'd120, 10'd321});
        chk("t2_wr", {log_q[1].wr, log_q[1].x, log_q[1].y, log_q[1].d},
            {1'b1, 10'd120, 10'd321, 48'hABC222333444});

        // Two same-word points coalesce
        log_q.delete();
        rd_force_q.push_back(48'h0);
        send(10'd120, 10'd5, 12'h001);
        send(10'd121, 10'd5, 12'h002);
        drain();
        chk("t3_len", 80'(log_q.size()), 80'd2);
        chk("t3_wr", {log_q[1].wr, log_q[1].x, log_q[1].y, log_q[1].d},
            {1'b1, 10'd120, 10'd5, 48'h000000002001});

        // Two different words keep order
        log_q.delete();
        send(10'd123, 10'd321, 12'h039);
        send(10'd234, 10'd432, 12'hBA0);
        drain();
        chk("t4_len", 80'(log_q.size()), 80'd4);
        chk("t4_order", {log_q[0].wr, log_q[0].x, log_q[1].wr, log_q[1].x,
                         log_q[2].wr, log_q[2].x, log_q[2].y, log_q[3].wr, log_q[3].x, log_q[3].y},
            {1'b0, 10'd120, 1'b1, 10'd120, 1'b0, 10'd232, 10'd432, 1'b1, 10'd232, 10'd432});
        chk("t4_lane", {68'h0, log_q[3].d[35:24]}, {68'h0, 12'hBA0});

        // Transparent mode
        transparent = 1'b1;
        log_q.delete();
        rd_force_q.push_back(48'hFFFFFFFFFFFF);
        send(10'd2, 10'd7, 12'h000);
        drain();
        chk("t5_zero", {log_q[1].wr, log_q[1].d}, {1'b1, 48'hFFFFFFFFFFFF});
        log_q.delete();
        rd_force_q.push_back(48'hFFFFFFFFFFFF);
        send(10'd2, 10'd7, 12'h5A5);
        drain();
        chk("t5_nonzero", {log_q[1].wr, log_q[1].d}, {1'b1, 48'hFFF5A5FFFFFF});
        log_q.delete();
        rd_force_q.push_back(48'hFFFFFFFFFFFF);
        send(10'd4, 10'd9, 12'h123);
        send(10'd5, 10'd9, 12'h000);
        drain();
        chk("t5_run", {80'(log_q.size()), log_q[1].d}, {80'd2, 48'hFFFFFFFFF123});
        transparent = 1'b0;

        // Back-pressure: ack withheld, five points fit
        log_q.delete();
        hold_ack = 1'b1;
        for (int i = 0; i < 5; i++) send(10'(i * 8), 10'(100 + i), 12'(i + 1));
        pt_flag = 1'b1; pt_x = 10'd40; pt_y = 10'd105; pt_pixel = 12'h006;
        repeat (4) begin
            @(negedge clock);
            chk("t6_full", {79'h0, done_pt}, 80'h0);
        end
        chk("t6_depth", 80'(exp_q.size()), 80'd5);
        hold_ack = 1'b0;
        send(10'd40, 10'd105, 12'h006);
        drain();
        chk("t6_len", 80'(log_q.size()), 80'd12);
        for (int i = 0; i < 6; i++)
            chk("t6_order", {log_q[2*i+1].wr, log_q[2*i+1].x, log_q[2*i+1].y},
                {1'b1, 10'(i * 8), 10'(100 + i)});

        // Reset in the middle of a read
        hold_ack = 1'b1;
        send(10'd40, 10'd50, 12'h321);
        t = 0;
        while (!ptf_flag && t < 50) begin
            @(negedge clock);
            t++;
        end
        chk("t1_in_read", {79'h0, ptf_flag}, 80'h1);
        reset = 1'b0;
        #1 chk("t1_reset_out", {ptf_flag, ptf_wr, ptf_x, ptf_y, ptf_pixel_write, done_pt}, 80'h0);
        exp_q.delete();
        log_q.delete();
        rd_force_q.delete();
        hold_ack = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1 chk("t1_pre_edge", {79'h0, done_pt}, 80'h0);
        @(negedge clock);
        chk("t1_ready", {79'h0, done_pt}, 80'h1);
        repeat (5) @(negedge clock);
        chk("t1_fifo_empty", {ptf_flag, log_q.size() == 0}, {1'b0, 1'b1});

        // Random runs of same-word points with distinct pixels
        prev_key = '1;
        for (int g = 0; g < 40; g++) begin
            do begin
                rx = 10'($urandom);
                ry = 10'($urandom);
            end while (key_of(rx, ry) == prev_key);
            prev_key = key_of(rx, ry);
            len = int'($urandom_range(1, 5));
            for (int i = 0; i < len; i++) begin
                do begin
                    p = 12'($urandom_range(1, 2047));
                    dup = 1'b0;
                    for (int j = 0; j < i; j++) if (used[j] == p) dup = 1'b1;
                end while (dup);
                used[i] = p;
                lane = int'($urandom_range(0, 3));
                send({rx[9:2], 2'(lane)}, ry, p);
                if ($urandom_range(0, 3) == 0) @(negedge clock);
            end
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
